// File: rtl/timebase_gen.sv
`default_nettype none
// ============================================================================
//  Module   : timebase_gen
//  Purpose  : Programmable prescaler followed by a chain of decade dividers.
//             Channel 0 is a square wave whose half-period is (term+1)
//             clocks. Each channel k>=1 divides the previous channel by ten.
//             Every channel emits a one-cycle tick once per period.
//  Ports    : clk      - single clock, rising edge
//             rst      - synchronous active-high reset (highest priority)
//             clr      - synchronous clear of counters and outputs
//             run      - count enable; 0 freezes all state, ticks forced low
//             ld       - load strobe for a new half-period terminal count
//             ld_val   - new half-period terminal count
//             sq       - square wave per channel
//             tick     - one-cycle pulse per channel period
//             term_cur - active terminal count
//  Config   : `define TIMEBASE_LOAD_EN enables the ld/ld_val path. Without
//             it the terminal count is fixed at DEF_HALF and ld/ld_val are
//             ignored.
//  Revision : 1.0 - initial release
// ============================================================================
module timebase_gen #(
    parameter int CNT_W    = 26,
    parameter int DEF_HALF = 24_999,
    parameter int N_CH     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             run,
    input  logic             ld,
    input  logic [CNT_W-1:0] ld_val,
    output logic [N_CH-1:0]  sq,
    output logic [N_CH-1:0]  tick,
    output logic [CNT_W-1:0] term_cur
);

    localparam logic [CNT_W-1:0] c_def_half = CNT_W'(DEF_HALF);
    localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);
    localparam logic [3:0]       c_dec_max  = 4'd9;
    localparam logic [3:0]       c_dec_half = 4'd5;

    logic [CNT_W-1:0] r_ctr;
    logic [CNT_W-1:0] w_term;
    logic             w_ld;
    logic             w_wrap;
    logic             r_sq0;
    logic             r_fall;      // sq[0] fell on the last active edge
    logic             r_tick0;
    logic [N_CH-1:0]  w_tick_st;   // tick state before run masking

    // ------------------------------------------------------------------
    // Terminal count register (optional load path)
    // ------------------------------------------------------------------
`ifdef TIMEBASE_LOAD_EN
    logic [CNT_W-1:0] r_term;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_term <= c_def_half;
        end else if (ld) begin
            r_term <= ld_val;
        end
    end

    assign w_term = r_term;
    assign w_ld   = ld;
`else
    logic w_unused_ld;

    assign w_unused_ld = ^{ld, ld_val};
    assign w_term      = c_def_half;
    assign w_ld        = 1'b0;
`endif

    assign term_cur = w_term;
    assign w_wrap   = (r_ctr == w_term);

    // ------------------------------------------------------------------
    // Prescaler and channel 0
    // The tick is produced one edge after the falling edge of sq[0], so a
    // flag remembers the fall. All of this only advances while run=1, which
    // lets a run=0 window simply drop out of the timeline without losing a
    // pending tick.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctr   <= '0;
            r_sq0   <= 1'b0;
            r_fall  <= 1'b0;
            r_tick0 <= 1'b0;
        end else if (clr) begin
            r_ctr   <= '0;
            r_sq0   <= 1'b0;
            r_fall  <= 1'b0;
            r_tick0 <= 1'b0;
        end else if (w_ld) begin
            // A load restarts the half-period; it beats a coincident wrap,
            // so sq[0] holds its level this cycle.
            r_ctr <= '0;
            if (run) begin
                r_tick0 <= r_fall;
                r_fall  <= 1'b0;
            end
        end else if (run) begin
            r_tick0 <= r_fall;
            if (w_wrap) begin
                r_ctr  <= '0;
                r_sq0  <= ~r_sq0;
                r_fall <= r_sq0;
            end else begin
                r_ctr  <= r_ctr + c_one;
                r_fall <= 1'b0;
            end
        end
    end

    assign w_tick_st[0] = r_tick0;
    assign sq[0]        = r_sq0;

    // ------------------------------------------------------------------
    // Decade channels: each counts ticks of the previous channel and
    // passes a tick on one cycle after its own wrap.
    // ------------------------------------------------------------------
    for (genvar k = 1; k < N_CH; k++) begin : g_dec
        logic [3:0] r_dec;
        logic       r_tick;

        always_ff @(posedge clk) begin
            if (rst || clr) begin
                r_dec  <= 4'd0;
                r_tick <= 1'b0;
            end else if (run) begin
                r_tick <= w_tick_st[k-1] && (r_dec == c_dec_max);
                if (w_tick_st[k-1]) begin
                    r_dec <= (r_dec == c_dec_max) ? 4'd0 : r_dec + 4'd1;
                end
            end
        end

        assign w_tick_st[k] = r_tick;
        assign sq[k]        = (r_dec >= c_dec_half);
    end

    // Ticks are held inside while frozen and only shown while running.
    assign tick = w_tick_st & {N_CH{run}};

endmodule
`default_nettype wire

// File: tb/tb_timebase_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_timebase_gen
//  Purpose  : Self-checking bench for timebase_gen (CNT_W=4, DEF_HALF=2,
//             N_CH=2). Stimulus queues time-stamped expected outputs; a
//             monitor compares them on the falling clock edge and flags any
//             tick that has no matching expectation.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_timebase_gen;

    localparam int CNT_W    = 4;
    localparam int DEF_HALF = 2;
    localparam int N_CH     = 2;

    localparam int R  = 2;          // reset release cycle
    localparam int R2 = R + 130;    // clear release cycle
    localparam int E  = R2 + 26;    // second reset cycle

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             clr = 1'b0;
    logic             run = 1'b0;
    logic             ld  = 1'b0;
    logic [CNT_W-1:0] ld_val = '0;
    logic [N_CH-1:0]  sq;
    logic [N_CH-1:0]  tick;
    logic [CNT_W-1:0] term_cur;

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;

    typedef struct {
        int         cyc;
        logic [1:0] sq;
        logic [1:0] tick;
        logic [3:0] term;
    } exp_t;

    exp_t q[$];

    timebase_gen #(
        .CNT_W    (CNT_W),
        .DEF_HALF (DEF_HALF),
        .N_CH     (N_CH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .run      (run),
        .ld       (ld),
        .ld_val   (ld_val),
        .sq       (sq),
        .tick     (tick),
        .term_cur (term_cur)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void expect_at(input int c, input logic [1:0] s,
                                      input logic [1:0] t, input logic [3:0] tc);
        exp_t e;
        e.cyc  = c;
        e.sq   = s;
        e.tick = t;
        e.term = tc;
        q.push_back(e);
    endfunction

    // Returns after edge n with inputs free to change for edge n+1.
    task automatic at_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        exp_t e;
        bit   hit;
        hit = 1'b0;
        while (q.size() > 0 && q[0].cyc < cyc) begin
            e = q.pop_front();
            n_checks++;
            n_fails++;
            $display("FAIL missed_expect cyc=%0d expected at cyc=%0d", cyc, e.cyc);
        end
        if (q.size() > 0 && q[0].cyc == cyc) begin
            e = q.pop_front();
            hit = 1'b1;
            n_checks++;
            if (sq !== e.sq || tick !== e.tick || term_cur !== e.term) begin
                n_fails++;
                $display("FAIL outputs cyc=%0d got sq=%b tick=%b term=%0d want sq=%b tick=%b term=%0d",
                         cyc, sq, tick, term_cur, e.sq, e.tick, e.term);
            end
        end
        if (!hit && tick !== 2'b00) begin
            n_checks++;
            n_fails++;
            $display("FAIL unexpected_tick cyc=%0d got tick=%b want tick=00", cyc, tick);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        // Reset state and free-running division: sq[0] every 3 clocks,
        // tick[0] every 6, tick[1] after ten tick[0] pulses.
        expect_at(R,     2'b00, 2'b00, 4'd2);
        expect_at(R + 3, 2'b01, 2'b00, 4'd2);
        expect_at(R + 5, 2'b01, 2'b00, 4'd2);
        expect_at(R + 6, 2'b00, 2'b00, 4'd2);
        for (int k = 0; k <= 10; k++) begin
            expect_at(R + 7 + 6 * k, {((k % 10) >= 5), 1'b0}, 2'b01, 4'd2);
            if (k == 9) expect_at(R + 62, 2'b00, 2'b10, 4'd2);
        end
        at_cyc(R);
        rst = 1'b0;
        run = 1'b1;

        // Seven-clock freeze mid-period: everything shifts by 7.
        expect_at(R + 72, 2'b01, 2'b00, 4'd2);
        expect_at(R + 75, 2'b01, 2'b00, 4'd2);
        expect_at(R + 78, 2'b01, 2'b00, 4'd2);
        expect_at(R + 79, 2'b00, 2'b00, 4'd2);
        expect_at(R + 80, 2'b00, 2'b01, 4'd2);
        at_cyc(R + 70);
        run = 1'b0;
        at_cyc(R + 77);
        run = 1'b1;

        // Clear on the cycle where dec[1]=9 and tick[0] is high.
        for (int j = 0; j <= 6; j++) begin
            expect_at(R + 86 + 6 * j, {((2 + j) >= 5), 1'b0}, 2'b01, 4'd2);
        end
        expect_at(R + 128, 2'b10, 2'b01, 4'd2);
        expect_at(R + 129, 2'b00, 2'b00, 4'd2);
        expect_at(R + 130, 2'b00, 2'b00, 4'd2);
        expect_at(R2 + 3,  2'b01, 2'b00, 4'd2);
        expect_at(R2 + 7,  2'b00, 2'b01, 4'd2);
        expect_at(R2 + 13, 2'b00, 2'b01, 4'd2);
        at_cyc(R + 128);
        clr = 1'b1;
        at_cyc(R + 130);
        clr = 1'b0;

        // Load of term=0 exactly when ctr==term.
`ifdef TIMEBASE_LOAD_EN
        expect_at(R2 + 15, 2'b00, 2'b00, 4'd0);
        expect_at(R2 + 16, 2'b01, 2'b00, 4'd0);
        expect_at(R2 + 17, 2'b00, 2'b00, 4'd0);
        for (int j = 0; j <= 4; j++) begin
            expect_at(R2 + 18 + 2 * j, {((2 + j) >= 5), 1'b1}, 2'b01, 4'd0);
        end
`else
        expect_at(R2 + 15, 2'b01, 2'b00, 4'd2);
        expect_at(R2 + 16, 2'b01, 2'b00, 4'd2);
        expect_at(R2 + 17, 2'b01, 2'b00, 4'd2);
        expect_at(R2 + 19, 2'b00, 2'b01, 4'd2);
        expect_at(R2 + 25, 2'b00, 2'b01, 4'd2);
`endif
        at_cyc(R2 + 14);
        ld     = 1'b1;
        ld_val = 4'd0;
        at_cyc(R2 + 15);
        ld     = 1'b0;

        // Reset together with clr, ld and run: reset wins, then first
        // tick[0] arrives 7 clocks after release.
        expect_at(E + 1, 2'b00, 2'b00, 4'd2);
        expect_at(E + 4, 2'b01, 2'b00, 4'd2);
        expect_at(E + 8, 2'b00, 2'b01, 4'd2);
        at_cyc(E);
        rst    = 1'b1;
        clr    = 1'b1;
        ld     = 1'b1;
        ld_val = 4'd5;
        run    = 1'b1;
        at_cyc(E + 1);
        rst = 1'b0;
        clr = 1'b0;
        ld  = 1'b0;

        at_cyc(E + 10);
        @(negedge clk);
        #1;
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_checks++;
            n_fails++;
            $display("FAIL never_checked expected at cyc=%0d now cyc=%0d", e.cyc, cyc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
